// File: rtl/mode_pkg.sv
// Mode encodings shared by the mode sequencer and the display multiplexer.
package mode_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_ARITH   = 2'b00;
  localparam mode_t MODE_LOGIC   = 2'b01;
  localparam mode_t MODE_COMPARE = 2'b10;
  localparam mode_t MODE_MAGIC   = 2'b11;

endpackage

// File: rtl/key_debounce.sv
// One push button: two-flop synchroniser, restart-on-bounce debounce counter,
// and a single-cycle pulse on each qualified press.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= raw_n;
      s2 <= s1;
    end
  end

  // level is kept as its own flop so it moves on exactly the same edge as stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        level  <= ~s2;
        cnt    <= '0;
        press  <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Debounces the next/previous buttons and steps a wrap-around display mode,
// with a one-cycle strobe whenever the mode actually changes.
module mode_sequencer
  import mode_pkg::*;
#(
  parameter int    DB_CYCLES  = 500000,
  parameter mode_t RESET_MODE = MODE_ARITH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        btn_n,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic [1:0]        btn_level
);

  logic [1:0] press;
  mode_t      mode_q;
  mode_t      mode_d;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (btn_n[0]),
    .level (btn_level[0]),
    .press (press[0])
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (btn_n[1]),
    .level (btn_level[1]),
    .press (press[1])
  );

  // Both buttons together act as a return-to-home gesture.
  always_comb begin
    mode_d = mode_q;
    case (press)
      2'b11:   mode_d = RESET_MODE;
      2'b01:   mode_d = mode_q + 2'd1;
      2'b10:   mode_d = mode_q - 2'd1;
      default: mode_d = mode_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= RESET_MODE;
      mode_changed <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      mode_changed <= (mode_d != mode_q);
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with a short debounce window (DB_CYCLES=4).
module tb_mode_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] btn_n;
  logic [1:0] mode;
  logic       mode_changed;
  logic [1:0] btn_level;

  int checks;
  int failures;

  mode_sequencer #(.DB_CYCLES(4), .RESET_MODE(2'b00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_n        (btn_n),
    .mode         (mode),
    .mode_changed (mode_changed),
    .btn_level    (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    btn_n = 2'b11;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== 2'b00) begin failures++; $display("FAIL reset_mode got=%b exp=00", mode); end
    checks++;
    if (mode_changed !== 1'b0) begin failures++; $display("FAIL reset_mc got=%b exp=0", mode_changed); end
    checks++;
    if (btn_level !== 2'b00) begin failures++; $display("FAIL reset_lvl got=%b exp=00", btn_level); end
    tick();
    tick();
    checks++;
    if (mode !== 2'b00 || mode_changed !== 1'b0) begin
      failures++; $display("FAIL reset_hold mode=%b mc=%b exp 00/0", mode, mode_changed);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // From mode 00, press next: commit at edge 6, mode 01 at edge 7.
  task automatic test_first_press();
    logic [1:0] em;
    btn_n = 2'b10;
    for (int e = 1; e <= 8; e++) begin
      tick();
      em = (e >= 7) ? 2'b01 : 2'b00;
      checks++;
      if (mode !== em) begin failures++; $display("FAIL first_mode e=%0d got=%b exp=%b", e, mode, em); end
      checks++;
      if (mode_changed !== (e == 7)) begin failures++; $display("FAIL first_mc e=%0d got=%b exp=%b", e, mode_changed, (e == 7)); end
      checks++;
      if (btn_level !== ((e >= 6) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL first_lvl e=%0d got=%b", e, btn_level);
      end
    end
    btn_n = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (mode !== 2'b01 || mode_changed !== 1'b0) begin
        failures++; $display("FAIL first_rel e=%0d mode=%b mc=%b exp 01/0", e, mode, mode_changed);
      end
      checks++;
      if (btn_level !== ((e >= 6) ? 2'b00 : 2'b01)) begin
        failures++; $display("FAIL first_rel_lvl e=%0d got=%b", e, btn_level);
      end
    end
  endtask

  // Seven next presses then two previous presses, starting from 01.
  task automatic test_wrap();
    logic [1:0] wbtn [9];
    logic [1:0] wexp [9];
    logic [1:0] prev_m;
    logic [1:0] em;
    wbtn = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    wexp = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10};
    prev_m = 2'b01;
    for (int p = 0; p < 9; p++) begin
      btn_n = wbtn[p];
      for (int e = 1; e <= 8; e++) begin
        tick();
        em = (e >= 7) ? wexp[p] : prev_m;
        checks++;
        if (mode !== em) begin failures++; $display("FAIL wrap_mode p=%0d e=%0d got=%b exp=%b", p, e, mode, em); end
        checks++;
        if (mode_changed !== (e == 7)) begin failures++; $display("FAIL wrap_mc p=%0d e=%0d got=%b", p, e, mode_changed); end
      end
      btn_n = 2'b11;
      for (int e = 1; e <= 8; e++) begin
        tick();
        checks++;
        if (mode !== wexp[p] || mode_changed !== 1'b0) begin
          failures++; $display("FAIL wrap_rel p=%0d e=%0d mode=%b mc=%b exp=%b", p, e, mode, mode_changed, wexp[p]);
        end
      end
      prev_m = wexp[p];
    end
  endtask

  // From 10: bit0 low 3 cycles, high 1, then held low; the bounce restarts
  // the count, so mode steps to 11 at edge 11 and nowhere else.
  task automatic test_bounce();
    logic [1:0] em;
    btn_n = 2'b10;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 3) btn_n = 2'b11;
      if (e == 4) btn_n = 2'b10;
      em = (e >= 11) ? 2'b11 : 2'b10;
      checks++;
      if (mode !== em) begin failures++; $display("FAIL bounce_mode e=%0d got=%b exp=%b", e, mode, em); end
      checks++;
      if (mode_changed !== (e == 11)) begin failures++; $display("FAIL bounce_mc e=%0d got=%b", e, mode_changed); end
    end
    btn_n = 2'b11;
    repeat (8) tick();
    btn_n = 2'b01;
    repeat (8) tick();
    checks++;
    if (mode !== 2'b10) begin failures++; $display("FAIL bounce_prev got=%b exp=10", mode); end
    btn_n = 2'b11;
    repeat (8) tick();
  endtask

  // Both buttons from 10 -> 00 with one strobe; again from 00 -> no strobe.
  task automatic test_simultaneous();
    logic [1:0] em;
    btn_n = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      tick();
      em = (e >= 7) ? 2'b00 : 2'b10;
      checks++;
      if (mode !== em) begin failures++; $display("FAIL both_mode e=%0d got=%b exp=%b", e, mode, em); end
      checks++;
      if (mode_changed !== (e == 7)) begin failures++; $display("FAIL both_mc e=%0d got=%b", e, mode_changed); end
    end
    checks++;
    if (btn_level !== 2'b11) begin failures++; $display("FAIL both_lvl got=%b exp=11", btn_level); end
    btn_n = 2'b11;
    repeat (8) tick();
    btn_n = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (mode !== 2'b00 || mode_changed !== 1'b0) begin
        failures++; $display("FAIL both_home e=%0d mode=%b mc=%b exp 00/0", e, mode, mode_changed);
      end
    end
    btn_n = 2'b11;
    repeat (8) tick();
  endtask

  // Long hold: one step only; release gives no step and level drops at edge 6.
  task automatic test_hold();
    logic [1:0] em;
    btn_n = 2'b10;
    for (int e = 1; e <= 100; e++) begin
      tick();
      em = (e >= 7) ? 2'b01 : 2'b00;
      checks++;
      if (mode !== em || mode_changed !== (e == 7)) begin
        failures++; $display("FAIL hold e=%0d mode=%b mc=%b exp=%b", e, mode, mode_changed, em);
      end
    end
    btn_n = 2'b11;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (mode !== 2'b01 || mode_changed !== 1'b0) begin
        failures++; $display("FAIL hold_rel e=%0d mode=%b mc=%b exp 01/0", e, mode, mode_changed);
      end
      checks++;
      if (btn_level !== ((e >= 6) ? 2'b00 : 2'b01)) begin
        failures++; $display("FAIL hold_rel_lvl e=%0d got=%b", e, btn_level);
      end
    end
  endtask

  // Reset mid-count with bit0 held; after release exactly one step to 01 at edge 7.
  task automatic test_reset_mid();
    logic [1:0] em;
    btn_n = 2'b10;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== 2'b00 || mode_changed !== 1'b0 || btn_level !== 2'b00) begin
      failures++; $display("FAIL rmid_async mode=%b mc=%b lvl=%b exp 00/0/00", mode, mode_changed, btn_level);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (mode !== 2'b00 || mode_changed !== 1'b0) begin
        failures++; $display("FAIL rmid_in_reset e=%0d mode=%b mc=%b", e, mode, mode_changed);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      em = (e >= 7) ? 2'b01 : 2'b00;
      checks++;
      if (mode !== em) begin failures++; $display("FAIL rmid_mode e=%0d got=%b exp=%b", e, mode, em); end
      checks++;
      if (mode_changed !== (e == 7)) begin failures++; $display("FAIL rmid_mc e=%0d got=%b", e, mode_changed); end
    end
    btn_n = 2'b11;
    repeat (8) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_first_press();
    test_wrap();
    test_bounce();
    test_simultaneous();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
